// File: rtl/mem_16bits_to_fifo_64bits_result_if.sv
// Bus bundle for the result-memory to 64-bit FIFO packer: control handshake,
// result-memory read port and FIFO write port.
interface mem_16bits_to_fifo_64bits_result_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        fifo_wr_en;
    logic [63:0] fifo_wr_data;
    logic        fifo_full;

    modport slave (
        input  start,
        input  mem_rd_data,
        input  fifo_full,
        output busy,
        output done,
        output mem_rd_en,
        output mem_rd_addr,
        output fifo_wr_en,
        output fifo_wr_data
    );

    modport master (
        output start,
        output mem_rd_data,
        output fifo_full,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  fifo_wr_en,
        input  fifo_wr_data
    );
endinterface

// File: rtl/mem_16bits_to_fifo_64bits_result.sv
// Reads NUM_WORDS 16-bit results from a synchronous memory and packs them,
// four per word (word 4k+i into lane i), into 64-bit FIFO pushes.
module mem_16bits_to_fifo_64bits_result #(
    parameter int NUM_WORDS = 43
) (
    input  logic                                clk,
    input  logic                                rst_n,
    mem_16bits_to_fifo_64bits_result_if.slave   bus
);
    localparam int CW = $clog2(NUM_WORDS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_PUSH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] END_CNT  = CW'(NUM_WORDS);

    logic [2:0]    r_state;
    logic [CW-1:0] r_word_cnt;
    logic [1:0]    r_lane;
    logic [63:0]   r_data;
    logic          w_push;

    assign w_push = (r_state == S_PUSH) && !bus.fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_lane     <= 2'd0;
            r_data     <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_RD;
                        r_word_cnt <= '0;
                        r_lane     <= 2'd0;
                        r_data     <= 64'd0;
                    end
                end
                S_RD: r_state <= S_CAP;
                S_CAP: begin
                    // Memory data is valid the cycle after the read strobe.
                    r_data[{r_lane, 4'b0000} +: 16] <= bus.mem_rd_data;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_lane     <= r_lane + 2'd1;
                    if (r_lane == 2'd3 || r_word_cnt == LAST_IDX)
                        r_state <= S_PUSH;
                    else
                        r_state <= S_RD;
                end
                S_PUSH: begin
                    if (w_push) begin
                        r_data  <= 64'd0;
                        r_lane  <= 2'd0;
                        r_state <= (r_word_cnt == END_CNT) ? S_DONE : S_RD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // busy covers the working states; it drops together with the done pulse.
    assign bus.busy         = (r_state == S_RD) || (r_state == S_CAP) || (r_state == S_PUSH);
    assign bus.done         = (r_state == S_DONE);
    assign bus.mem_rd_en    = (r_state == S_RD);
    assign bus.mem_rd_addr  = (r_state == S_RD) ? {{(32-CW){1'b0}}, r_word_cnt} : 32'd0;
    assign bus.fifo_wr_en   = w_push;
    assign bus.fifo_wr_data = r_data;
endmodule

// File: tb/tb_mem_16bits_to_fifo_64bits_result.sv
// Directed bench: three packer instances (43, 8 and 1 words) sharing one
// memory image; expected pushes are queued up front and popped on each push.
module tb_mem_16bits_to_fifo_64bits_result;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_16bits_to_fifo_64bits_result_if bus0();
    mem_16bits_to_fifo_64bits_result_if bus1();
    mem_16bits_to_fifo_64bits_result_if bus2();

    mem_16bits_to_fifo_64bits_result #(.NUM_WORDS(43)) u_dut43 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mem_16bits_to_fifo_64bits_result #(.NUM_WORDS(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_16bits_to_fifo_64bits_result #(.NUM_WORDS(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [15:0] mem [0:63];

    always @(posedge clk) begin
        if (bus0.mem_rd_en) bus0.mem_rd_data <= mem[bus0.mem_rd_addr[5:0]];
        if (bus1.mem_rd_en) bus1.mem_rd_data <= mem[bus1.mem_rd_addr[5:0]];
        if (bus2.mem_rd_en) bus2.mem_rd_data <= mem[bus2.mem_rd_addr[5:0]];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel      = 0;
    logic [63:0] exp_q [$];
    int          exp_addr, push_cnt, busy_cnt, done_cnt, done_at;

    logic        m_busy, m_done, m_rd_en, m_wr_en;
    logic [31:0] m_addr;
    logic [63:0] m_data;

    always_comb begin
        m_busy  = bus0.busy;
        m_done  = bus0.done;
        m_rd_en = bus0.mem_rd_en;
        m_wr_en = bus0.fifo_wr_en;
        m_addr  = bus0.mem_rd_addr;
        m_data  = bus0.fifo_wr_data;
        if (sel == 1) begin
            m_busy  = bus1.busy;
            m_done  = bus1.done;
            m_rd_en = bus1.mem_rd_en;
            m_wr_en = bus1.fifo_wr_en;
            m_addr  = bus1.mem_rd_addr;
            m_data  = bus1.fifo_wr_data;
        end else if (sel == 2) begin
            m_busy  = bus2.busy;
            m_done  = bus2.done;
            m_rd_en = bus2.mem_rd_en;
            m_wr_en = bus2.fifo_wr_en;
            m_addr  = bus2.mem_rd_addr;
            m_data  = bus2.fifo_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f);
        case (sel)
            0:       begin bus0.start = s; bus0.fifo_full = f; end
            1:       begin bus1.start = s; bus1.fifo_full = f; end
            default: begin bus2.start = s; bus2.fifo_full = f; end
        endcase
    endtask

    task automatic load_expect(input int nw);
        logic [63:0] w;
        exp_q.delete();
        for (int g = 0; g < (nw + 3) / 4; g++) begin
            w = 64'd0;
            for (int l = 0; l < 4; l++)
                if (4 * g + l < nw) w[16*l +: 16] = mem[4*g + l];
            exp_q.push_back(w);
        end
    endtask

    // Steps one cycle at a time: inputs driven at posedge+1, outputs sampled at posedge+2.
    task automatic run(input int restart_at, input int stall_at, input int stall_len,
                       input int abort_at, input int bound);
        logic [63:0] stall_data;
        exp_addr = 0; push_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        stall_data = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0);
        for (int n = 1; n <= bound; n++) begin
            @(posedge clk); #1;
            drive(n == restart_at,
                  stall_at >= 0 && n >= stall_at && n <= stall_at + stall_len);
            if (n == abort_at) begin
                rst_n = 1'b0;
                return;
            end
            #1;
            if (m_rd_en) begin
                chk("rd_addr", 64'(m_addr), 64'(exp_addr));
                exp_addr++;
            end
            if (m_wr_en) begin
                push_cnt++;
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL push_unexpected: observed data %h expected no push", m_data);
                end
                if (exp_q.size() > 0) chk("push_data", m_data, exp_q.pop_front());
            end
            if (stall_at >= 0 && n > stall_at && n <= stall_at + stall_len) begin
                chk("stall_wr_en", 64'(m_wr_en), 64'd0);
                chk("stall_data", m_data, stall_data);
            end
            if (m_busy) busy_cnt++;
            if (m_done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && n >= done_at + 3) break;
        end
        if (abort_at < 0 && done_at < 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL done_timeout: observed no done within %0d cycles expected done", bound);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus0.busy, bus0.done, bus0.mem_rd_en, bus0.fifo_wr_en, bus0.mem_rd_addr}, 64'd0);
        chk({tag, "_data"}, bus0.fifo_wr_data, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        for (int b = 0; b < 3; b++) begin
            sel = b;
            drive(1'b0, 1'b0);
        end
        sel = 0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle after reset with no start
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            chk("idle_outputs", {60'd0, m_busy, m_done, m_rd_en, m_wr_en}, 64'd0);
        end

        // 43-word transfer, no backpressure
        $display("transfer: 43 words, no backpressure");
        load_expect(43);
        run(-1, -1, 0, -1, 300);
        chk("t2_push_count", 64'(push_cnt), 64'd11);
        chk("t2_done_at", 64'(done_at), 64'd98);
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd97);
        chk("t2_done_width", 64'(done_cnt), 64'd1);
        chk("t2_queue_left", 64'(exp_q.size()), 64'd0);

        // 8-word transfer with a 5-cycle FIFO-full stall on the first push
        $display("transfer: 8 words, fifo_full stall");
        sel = 1;
        load_expect(8);
        run(-1, 8, 5, -1, 200);
        chk("t3_push_count", 64'(push_cnt), 64'd2);
        chk("t3_done_at", 64'(done_at), 64'd24);
        chk("t3_queue_left", 64'(exp_q.size()), 64'd0);

        // 8-word transfer with start re-pulsed while busy
        $display("transfer: 8 words, start while busy");
        load_expect(8);
        run(5, -1, 0, -1, 200);
        chk("t4_push_count", 64'(push_cnt), 64'd2);
        chk("t4_done_at", 64'(done_at), 64'd19);
        chk("t4_busy_cycles", 64'(busy_cnt), 64'd18);
        chk("t4_queue_left", 64'(exp_q.size()), 64'd0);

        // Reset asserted after the second push, then a fresh transfer
        $display("transfer: 43 words, reset after second push");
        sel = 0;
        load_expect(43);
        run(-1, -1, 0, 19, 300);
        chk("t5_push_before_reset", 64'(push_cnt), 64'd2);
        #1;
        chk_all_zero("t5_reset_immediate");
        repeat (2) begin
            @(posedge clk); #2;
            chk_all_zero("t5_reset_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_expect(43);
        run(-1, -1, 0, -1, 300);
        chk("t5_push_count", 64'(push_cnt), 64'd11);
        chk("t5_done_at", 64'(done_at), 64'd98);
        chk("t5_queue_left", 64'(exp_q.size()), 64'd0);

        // Single-word transfer
        $display("transfer: 1 word");
        sel = 2;
        mem[0] = 16'hBEEF;
        load_expect(1);
        run(-1, -1, 0, -1, 50);
        chk("t6_push_count", 64'(push_cnt), 64'd1);
        chk("t6_done_at", 64'(done_at), 64'd4);
        chk("t6_queue_left", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
